// File: rtl/mont_seq_pkg.sv
// Shared types for the Montgomery squaring sequencer: FSM state encoding and
// multiplier mode codes.
package mont_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ,
    ST_W_SQ,
    ST_LO,
    ST_W_LO,
    ST_HI,
    ST_W_HI,
    ST_DONE
  } mont_seq_state_t;

  localparam logic [1:0] MUL_CTL_LO = 2'd0;
  localparam logic [1:0] MUL_CTL_HI = 2'd1;
  localparam logic [1:0] MUL_CTL_SQ = 2'd2;

endpackage

// File: rtl/mont_add_term_gen.sv
// Builds the add term for the high-half reduction multiply: T_hi with limb 0
// bumped by the implicit carry out of T_lo + (m*N)_lo (1 whenever T_lo != 0).
module mont_add_term_gen #(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17
) (
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0] t_hi_i,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0] t_lo_i,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0] add_o
);

  localparam int VEC_W = DSP_BIT_LEN * NUM_ELEMENTS;

  logic [DSP_BIT_LEN-1:0] limb0;

  // Redundant form: the increment stays inside limb 0, no carry propagation.
  assign limb0 = t_hi_i[DSP_BIT_LEN-1:0] + {{(DSP_BIT_LEN-1){1'b0}}, |t_lo_i};
  assign add_o = {t_hi_i[VEC_W-1:DSP_BIT_LEN], limb0};

endmodule

// File: rtl/mont_sq_sequencer.sv
// Drives an external multiplier through K Montgomery squarings x <- x^2*R^-1 mod N.
// Optional watchdog and sticky o_err port: define MONT_SEQ_TIMEOUT_EN.
module mont_sq_sequencer
  import mont_seq_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16,
  parameter int MUL_LATENCY  = 3,
  parameter int ITER_W       = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_val,
  output logic                                  o_rdy,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_dat,
  input  logic [ITER_W-1:0]                     i_num_iter,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_mod,
  input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_mod_inv,
  output logic                                  o_val,
  input  logic                                  i_rdy,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_dat,
  output logic                                  o_mul_val,
  output logic [1:0]                            o_mul_ctl,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_mul_a,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_mul_b,
  output logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   o_mul_add,
  input  logic                                  i_mul_val,
  input  logic [DSP_BIT_LEN*2*NUM_ELEMENTS-1:0] i_mul_dat,
`ifdef MONT_SEQ_TIMEOUT_EN
  output logic                                  o_err,
`endif
  output logic                                  o_busy
);

  localparam int VEC_W = DSP_BIT_LEN * NUM_ELEMENTS;

  if (WORD_LEN >= DSP_BIT_LEN) begin : g_chk_word_len
    $error("WORD_LEN must leave at least one redundant bit per limb");
  end
  if (MUL_LATENCY < 1) begin : g_chk_mul_latency
    $error("MUL_LATENCY must be at least 1");
  end

  mont_seq_state_t   state_q, state_d;
  logic [VEC_W-1:0]  x_q, x_d;
  logic [VEC_W-1:0]  t_lo_q, t_lo_d;
  logic [VEC_W-1:0]  t_hi_q, t_hi_d;
  logic [VEC_W-1:0]  m_q, m_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0]  hi_add;

`ifdef MONT_SEQ_TIMEOUT_EN
  localparam int WD_LIMIT = MUL_LATENCY + 2;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  assign o_err = err_q;
`endif

  mont_add_term_gen #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .DSP_BIT_LEN  (DSP_BIT_LEN)
  ) u_add_term (
    .t_hi_i (t_hi_q),
    .t_lo_i (t_lo_q),
    .add_o  (hi_add)
  );

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no path infers a latch.
    state_d   = state_q;
    x_d       = x_q;
    t_lo_d    = t_lo_q;
    t_hi_d    = t_hi_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    o_rdy     = 1'b0;
    o_val     = 1'b0;
    o_mul_val = 1'b0;
    o_mul_ctl = MUL_CTL_LO;
    o_mul_a   = '0;
    o_mul_b   = '0;
    o_mul_add = '0;
`ifdef MONT_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        o_rdy = 1'b1;
        if (i_val) begin
          x_d     = i_dat;
          cnt_d   = i_num_iter;
          state_d = (i_num_iter == '0) ? ST_DONE : ST_SQ;
`ifdef MONT_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_SQ: begin
        o_mul_val = 1'b1;
        o_mul_ctl = MUL_CTL_SQ;
        o_mul_a   = x_q;
        o_mul_b   = x_q;
        state_d   = ST_W_SQ;
      end
      ST_W_SQ: if (i_mul_val) begin
        t_lo_d  = i_mul_dat[VEC_W-1:0];
        t_hi_d  = i_mul_dat[2*VEC_W-1:VEC_W];
        state_d = ST_LO;
      end
      ST_LO: begin
        o_mul_val = 1'b1;
        o_mul_ctl = MUL_CTL_LO;
        o_mul_a   = t_lo_q;
        o_mul_b   = i_mod_inv;
        state_d   = ST_W_LO;
      end
      ST_W_LO: if (i_mul_val) begin
        m_d     = i_mul_dat[VEC_W-1:0];
        state_d = ST_HI;
      end
      ST_HI: begin
        o_mul_val = 1'b1;
        o_mul_ctl = MUL_CTL_HI;
        o_mul_a   = m_q;
        o_mul_b   = i_mod;
        o_mul_add = hi_add;
        state_d   = ST_W_HI;
      end
      ST_W_HI: if (i_mul_val) begin
        x_d     = i_mul_dat[2*VEC_W-1:VEC_W];
        cnt_d   = cnt_q - ITER_W'(1);
        state_d = (cnt_q == ITER_W'(1)) ? ST_DONE : ST_SQ;
      end
      ST_DONE: begin
        o_val = 1'b1;
        if (i_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MONT_SEQ_TIMEOUT_EN
    // A result arriving on the last allowed wait cycle still wins over the timeout.
    if (state_q inside {ST_W_SQ, ST_W_LO, ST_W_HI}) begin
      if (!i_mul_val) begin
        if (wd_q == WD_W'(WD_LIMIT)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
    end else begin
      if (state_q inside {ST_SQ, ST_LO, ST_HI}) wd_d = '0;
      if (i_mul_val) err_d = 1'b1;
    end
`endif
  end

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      t_lo_q  <= '0;
      t_hi_q  <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
`ifdef MONT_SEQ_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      t_lo_q  <= t_lo_d;
      t_hi_q  <= t_hi_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
`ifdef MONT_SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_dat  = x_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mont_sq_sequencer.sv
// Self-checking bench for mont_sq_sequencer with a latency-3 multiplier model
// and a modular-arithmetic reference for repeated Montgomery squaring.
module tb_mont_sq_sequencer;

  localparam int NE = 4;
  localparam int DW = 17;
  localparam int WL = 16;
  localparam int L  = 3;
  localparam int IW = 32;
  localparam int VW = DW * NE;
  localparam logic [63:0] MOD_N = 64'hFFF1_0000_0000_0007;

  logic            clk = 1'b0;
  logic            i_rst_n = 1'b1;
  logic            i_val = 1'b0, i_rdy = 1'b0;
  logic [VW-1:0]   i_dat = '0, i_mod = '0, i_mod_inv = '0;
  logic [IW-1:0]   i_num_iter = '0;
  logic            o_rdy, o_val, o_busy, o_mul_val;
  logic [VW-1:0]   o_dat, o_mul_a, o_mul_b, o_mul_add;
  logic [1:0]      o_mul_ctl;
  logic            i_mul_val;
  logic [2*VW-1:0] i_mul_dat;
`ifdef MONT_SEQ_TIMEOUT_EN
  logic            o_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] n_prime, r_mod_n, r_inv;

  // Multiplier model state
  logic            mul_stall = 1'b0;
  logic            pv[3];
  logic [2*VW-1:0] pd[3];
  logic [1:0]      ctl_log[$];
  int              mul_pulses = 0;
  int              idle_ops_bad = 0;

  mont_sq_sequencer #(
    .NUM_ELEMENTS (NE), .DSP_BIT_LEN (DW), .WORD_LEN (WL),
    .MUL_LATENCY (L), .ITER_W (IW)
  ) dut (
    .i_clk (clk), .i_rst_n (i_rst_n), .i_val (i_val), .o_rdy (o_rdy),
    .i_dat (i_dat), .i_num_iter (i_num_iter), .i_mod (i_mod), .i_mod_inv (i_mod_inv),
    .o_val (o_val), .i_rdy (i_rdy), .o_dat (o_dat),
    .o_mul_val (o_mul_val), .o_mul_ctl (o_mul_ctl), .o_mul_a (o_mul_a),
    .o_mul_b (o_mul_b), .o_mul_add (o_mul_add),
    .i_mul_val (i_mul_val), .i_mul_dat (i_mul_dat),
`ifdef MONT_SEQ_TIMEOUT_EN
    .o_err (o_err),
`endif
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack_val(input logic [63:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*DW +: DW] = {1'b0, v[i*WL +: WL]};
    return r;
  endfunction

  function automatic logic [127:0] unpack_val(input logic [VW-1:0] p);
    logic [127:0] r = '0;
    for (int i = 0; i < NE; i++) r = r + (128'(p[i*DW +: DW]) << (i*WL));
    return r;
  endfunction

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p = 128'(a) * 128'(b);
    return 64'(p % 128'(MOD_N));
  endfunction

  // x^(2^k) * R^-(2^k - 1) mod N, one modular Montgomery step at a time.
  function automatic logic [63:0] ref_mont(input logic [63:0] x, input int k);
    logic [63:0] r = 64'(128'(x) % 128'(MOD_N));
    for (int i = 0; i < k; i++) r = mulmod(mulmod(r, r), r_inv);
    return r;
  endfunction

  // Multiplier behaviour: full square, low half of a*b, or (high half of a*b + add).
  // The high-half result is returned reduced mod N, which keeps limbs in range
  // and only changes the final value by a multiple of N.
  function automatic logic [2*VW-1:0] mul_model(input logic [1:0] ctl, input logic [VW-1:0] a,
                                                input logic [VW-1:0] b, input logic [VW-1:0] add);
    logic [255:0]    p, hh;
    logic [2*VW-1:0] r = '0;
    p = 256'(unpack_val(a)) * 256'(unpack_val(b));
    case (ctl)
      2'd2: for (int i = 0; i < 2*NE; i++) r[i*DW +: DW] = {1'b0, p[i*WL +: WL]};
      2'd0: for (int i = 0; i < NE; i++) r[i*DW +: DW] = {1'b0, p[i*WL +: WL]};
      2'd1: begin
        hh = ((p >> (WL*NE)) + 256'(unpack_val(add))) % 256'(MOD_N);
        for (int i = 0; i < NE; i++) r[(NE+i)*DW +: DW] = {1'b0, hh[i*WL +: WL]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  initial begin
    i_mul_val = 1'b0;
    i_mul_dat = '0;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    forever begin
      @(negedge clk);
      i_mul_val = pv[2] && !mul_stall;
      i_mul_dat = pd[2];
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = o_mul_val;
      pd[0] = o_mul_val ? mul_model(o_mul_ctl, o_mul_a, o_mul_b, o_mul_add) : '0;
      if (o_mul_val) begin
        ctl_log.push_back(o_mul_ctl);
        mul_pulses++;
      end else if (o_mul_ctl != 2'd0 || o_mul_a != '0 || o_mul_b != '0 || o_mul_add != '0) begin
        idle_ops_bad++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "global timeout");
  end

  // Accept a start at the edge after the current negedge; returns at the negedge of cycle 1.
  task automatic start_req(input logic [63:0] x, input logic [IW-1:0] k);
    @(negedge clk);
    ctl_log.delete();
    mul_pulses = 0;
    i_val = 1'b1; i_dat = pack_val(x); i_num_iter = k;
    @(negedge clk);
    i_val = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, output int cyc);
    cyc = start;
    while (!o_val && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_done;
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;
  endtask

  task automatic test_reset;
    #2 i_rst_n = 1'b0;
    @(negedge clk);
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", o_rdy); end
    checks++; if ({o_val, o_busy, o_mul_val} !== 3'b000) begin errors++; $display("FAIL reset_flags: val/busy/mul_val got %b want 000", {o_val, o_busy, o_mul_val}); end
    checks++; if (o_mul_ctl !== 2'd0) begin errors++; $display("FAIL reset_ctl: got %0d want 0", o_mul_ctl); end
    checks++; if (o_dat !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", o_dat); end
    checks++; if ({o_mul_a, o_mul_b, o_mul_add} !== '0) begin errors++; $display("FAIL reset_operands: got nonzero operands"); end
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_rdy !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_release: rdy=%b busy=%b want 1/0", o_rdy, o_busy); end
  endtask

  task automatic test_fixed_point;
    int cyc;
    logic [127:0] got;
    start_req(r_mod_n, 1);
    wait_done(1, 100, cyc);
    checks++; if (cyc !== 13 || o_val !== 1'b1) begin errors++; $display("FAIL fixed_point_latency: got cycle %0d val %b want cycle 13", cyc, o_val); end
    got = unpack_val(o_dat) % 128'(MOD_N);
    checks++; if (got !== 128'(r_mod_n)) begin errors++; $display("FAIL fixed_point_value: got %h want %h", got, r_mod_n); end
    checks++; if (ctl_log.size() != 3 || ctl_log[0] !== 2'd2 || ctl_log[1] !== 2'd0 || ctl_log[2] !== 2'd1) begin
      errors++; $display("FAIL fixed_point_ctl: got %0d ops, want sequence 2,0,1", ctl_log.size());
    end
    release_done();
  endtask

  task automatic test_zero_k5;
    int cyc;
    int bad = 0;
    logic [127:0] got;
    start_req(64'd0, 5);
    wait_done(1, 200, cyc);
    checks++; if (cyc !== 61 || o_val !== 1'b1) begin errors++; $display("FAIL zero_latency: got cycle %0d val %b want cycle 61", cyc, o_val); end
    got = unpack_val(o_dat) % 128'(MOD_N);
    checks++; if (got !== 128'd0) begin errors++; $display("FAIL zero_value: got %h want 0", got); end
    for (int i = 0; i < ctl_log.size(); i++)
      if (ctl_log[i] !== ((i % 3 == 0) ? 2'd2 : (i % 3 == 1) ? 2'd0 : 2'd1)) bad++;
    checks++; if (ctl_log.size() != 15 || bad != 0) begin errors++; $display("FAIL zero_ctl_seq: got %0d ops with %0d wrong, want 15 ops 2,0,1 repeating", ctl_log.size(), bad); end
    release_done();
  endtask

  task automatic test_k0;
    int cyc;
    start_req(64'h1234, 0);
    wait_done(1, 20, cyc);
    checks++; if (cyc !== 1 || o_val !== 1'b1) begin errors++; $display("FAIL k0_latency: got cycle %0d val %b want cycle 1", cyc, o_val); end
    checks++; if (o_dat !== pack_val(64'h1234)) begin errors++; $display("FAIL k0_value: got %h want %h", o_dat, pack_val(64'h1234)); end
    checks++; if (mul_pulses != 0) begin errors++; $display("FAIL k0_no_mul: got %0d issues want 0", mul_pulses); end
    release_done();
  endtask

  task automatic test_hold;
    int cyc;
    int unstable = 0;
    logic [63:0]   x, exp;
    logic [127:0]  got;
    logic [VW-1:0] held;
    x = {$urandom(), $urandom()} % MOD_N;
    exp = ref_mont(x, 3);
    start_req(x, 3);
    @(negedge clk);
    i_val = 1'b1; i_dat = pack_val(64'hDEAD_BEEF); i_num_iter = 0;
    checks++; if (o_rdy !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL busy_rdy: rdy=%b busy=%b want 0/1", o_rdy, o_busy); end
    @(negedge clk);
    i_val = 1'b0;
    wait_done(3, 200, cyc);
    checks++; if (cyc !== 37 || o_val !== 1'b1) begin errors++; $display("FAIL hold_latency: got cycle %0d val %b want cycle 37", cyc, o_val); end
    got = unpack_val(o_dat) % 128'(MOD_N);
    checks++; if (got !== 128'(exp)) begin errors++; $display("FAIL hold_value: got %h want %h", got, exp); end
    held = o_dat;
    repeat (10) begin
      @(negedge clk);
      if (o_dat !== held || o_val !== 1'b1) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles want 0", unstable); end
    i_rdy = 1'b1;
    checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL done_rdy: got %b want 0", o_rdy); end
    @(negedge clk);
    i_rdy = 1'b0;
    checks++; if (o_rdy !== 1'b1 || o_val !== 1'b0) begin errors++; $display("FAIL rdy_after_accept: rdy=%b val=%b want 1/0", o_rdy, o_val); end
  endtask

  task automatic test_reset_midop;
    start_req({$urandom(), $urandom()} % MOD_N, 2);
    repeat (5) @(negedge clk);
    checks++; if (mul_pulses != 2 || o_busy !== 1'b1) begin errors++; $display("FAIL midop_position: got %0d issues busy %b want 2/1", mul_pulses, o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_rdy, o_val, o_busy, o_mul_val} !== 4'b1000 || o_dat !== '0) begin
      errors++; $display("FAIL midop_reset: rdy/val/busy/mul_val got %b dat %h want 1000/0", {o_rdy, o_val, o_busy, o_mul_val}, o_dat);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({o_rdy, o_val, o_busy, o_mul_val} !== 4'b1000 || o_dat !== '0) begin
      errors++; $display("FAIL midop_stale: rdy/val/busy/mul_val got %b dat %h want 1000/0", {o_rdy, o_val, o_busy, o_mul_val}, o_dat);
    end
  endtask

  task automatic test_random;
    int cyc, k;
    logic [63:0]  x, exp;
    logic [127:0] got;
    for (int n = 0; n < 3; n++) begin
      k = int'($urandom_range(4, 1));
      x = {$urandom(), $urandom()} % MOD_N;
      exp = ref_mont(x, k);
      start_req(x, IW'(k));
      wait_done(1, 200, cyc);
      checks++; if (cyc !== 1 + 12*k || o_val !== 1'b1) begin errors++; $display("FAIL random_latency: k=%0d got cycle %0d want %0d", k, cyc, 1 + 12*k); end
      got = unpack_val(o_dat) % 128'(MOD_N);
      checks++; if (got !== 128'(exp)) begin errors++; $display("FAIL random_value: k=%0d got %h want %h", k, got, exp); end
      release_done();
    end
  endtask

  task automatic test_max_iter;
    start_req(64'd5, '1);
    repeat (100) @(negedge clk);
    checks++; if (o_val !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL max_iter_running: val=%b busy=%b want 0/1", o_val, o_busy); end
    i_rst_n = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

`ifdef MONT_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    mul_stall = 1'b1;
    start_req(64'd7, 1);
    wait_done(1, 50, cyc);
    checks++; if (cyc !== 8 || o_val !== 1'b1) begin errors++; $display("FAIL timeout_latency: got cycle %0d val %b want cycle 8", cyc, o_val); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", o_err); end
    release_done();
    checks++; if (o_err !== 1'b1 || o_rdy !== 1'b1) begin errors++; $display("FAIL timeout_sticky: err=%b rdy=%b want 1/1", o_err, o_rdy); end
    mul_stall = 1'b0;
    repeat (4) @(negedge clk);
    start_req(64'd9, 0);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", o_err); end
    release_done();
  endtask
`endif

  task automatic test_idle_operands;
    checks++; if (idle_ops_bad != 0) begin errors++; $display("FAIL idle_operands: %0d cycles with nonzero operands while idle, want 0", idle_ops_bad); end
  endtask

  initial begin
    logic [63:0] inv;
    inv = MOD_N;
    repeat (6) inv = inv * (64'd2 - MOD_N * inv);
    n_prime = -inv;
    r_mod_n = 64'((128'd1 << 64) % 128'(MOD_N));
    r_inv = 64'd1;
    repeat (64) r_inv = mulmod(r_inv, (MOD_N >> 1) + 64'd1);
    i_mod = pack_val(MOD_N);
    i_mod_inv = pack_val(n_prime);

    test_reset();
    test_fixed_point();
    test_zero_k5();
    test_k0();
    test_hold();
    test_reset_midop();
    test_random();
    test_max_iter();
`ifdef MONT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_idle_operands();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
